// File: rtl/turn_sched.sv
// Two-player turn scheduler sharing one target/compare datapath between players A and B.
// Sequences target generation, guess arbitration, per-player tries, result LEDs and winner.
module turn_sched #(
  parameter int WIDTH     = 8,
  parameter int MAX_TRIES = 7,
  parameter int TRY_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter_a,
  input  logic             enter_b,
  input  logic             new_game,
  input  logic [WIDTH-1:0] guess_a,
  input  logic [WIDTH-1:0] guess_b,
  output logic [WIDTH-1:0] cmp_guess,
  input  logic             cmp_over,
  input  logic             cmp_under,
  input  logic             cmp_equal,
  output logic             run_target,
  output logic             turn,
  output logic [TRY_W-1:0] tries_a,
  output logic [TRY_W-1:0] tries_b,
  output logic             led_over,
  output logic             led_under,
  output logic             led_equal,
  output logic [1:0]       winner,
  output logic             game_over
);

  localparam logic [TRY_W-1:0] TRIES_INIT = TRY_W'(MAX_TRIES);

  typedef enum logic [2:0] {S_GEN, S_WAIT, S_REL, S_CHECK, S_END} state_t;

  state_t           state;
  logic             enter_a_q, enter_b_q, new_game_q;
  logic             press_a, press_b, press_turn, enter_turn, new_game_rise;
  logic [TRY_W-1:0] next_a, next_b;

  assign press_a       = enter_a & ~enter_a_q;
  assign press_b       = enter_b & ~enter_b_q;
  assign press_turn    = turn ? press_b : press_a;
  assign enter_turn    = turn ? enter_b : enter_a;
  assign new_game_rise = new_game & ~new_game_q;

  assign run_target = (state == S_GEN);
  assign game_over  = (state == S_END);

  // Post-decrement tries of the turn player, saturating at zero.
  always_comb begin
    next_a = tries_a;
    next_b = tries_b;
    if (!turn) begin
      if (tries_a != '0) next_a = tries_a - 1'b1;
    end else begin
      if (tries_b != '0) next_b = tries_b - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_GEN;
      turn       <= 1'b0;
      tries_a    <= TRIES_INIT;
      tries_b    <= TRIES_INIT;
      cmp_guess  <= '0;
      led_over   <= 1'b0;
      led_under  <= 1'b0;
      led_equal  <= 1'b0;
      winner     <= 2'b00;
      enter_a_q  <= 1'b0;
      enter_b_q  <= 1'b0;
      new_game_q <= 1'b0;
    end else begin
      enter_a_q  <= enter_a;
      enter_b_q  <= enter_b;
      new_game_q <= new_game;
      case (state)
        S_GEN: begin
          if (press_a) begin
            turn  <= 1'b0;
            state <= S_REL;
          end
        end
        S_WAIT: begin
          if (press_turn) state <= S_REL;
        end
        S_REL: begin
          if (!enter_turn) begin
            cmp_guess <= turn ? guess_b : guess_a;
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          led_over  <= cmp_over;
          led_under <= cmp_under;
          led_equal <= cmp_equal;
          tries_a   <= next_a;
          tries_b   <= next_b;
          if (cmp_equal) begin
            winner <= turn ? 2'b10 : 2'b01;
            state  <= S_END;
          end else if (next_a == '0 && next_b == '0) begin
            winner <= 2'b11;
            state  <= S_END;
          end else begin
            // An exhausted opponent forfeits turns; the remaining player keeps going.
            if (turn ? (next_a != '0) : (next_b != '0)) turn <= ~turn;
            state <= S_WAIT;
          end
        end
        S_END: begin
          if (new_game_rise) begin
            tries_a   <= TRIES_INIT;
            tries_b   <= TRIES_INIT;
            led_over  <= 1'b0;
            led_under <= 1'b0;
            led_equal <= 1'b0;
            winner    <= 2'b00;
            turn      <= 1'b0;
            state     <= S_GEN;
          end
        end
        default: state <= S_GEN;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_sched.sv
// Directed bench for turn_sched: two instances (default tries and MAX_TRIES=2),
// each with a small target-counter/comparator model standing in for the shared datapath.
module tb_turn_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance 1: default parameters
  logic       rst1, enter_a1, enter_b1, new_game1;
  logic [7:0] guess_a1, guess_b1, cg1, tgt1;
  logic       over1, under1, equal1, run1, turn1, lo1, lu1, le1, go1;
  logic [3:0] ta1, tb1;
  logic [1:0] win1;

  // Instance 2: MAX_TRIES=2
  logic       rst2, enter_a2, enter_b2, new_game2;
  logic [7:0] guess_a2, guess_b2, cg2, tgt2;
  logic       over2, under2, equal2, run2, turn2, lo2, lu2, le2, go2;
  logic [3:0] ta2, tb2;
  logic [1:0] win2;

  logic [7:0] saved;

  turn_sched dut1 (
    .clk(clk), .reset(rst1), .enter_a(enter_a1), .enter_b(enter_b1), .new_game(new_game1),
    .guess_a(guess_a1), .guess_b(guess_b1), .cmp_guess(cg1),
    .cmp_over(over1), .cmp_under(under1), .cmp_equal(equal1),
    .run_target(run1), .turn(turn1), .tries_a(ta1), .tries_b(tb1),
    .led_over(lo1), .led_under(lu1), .led_equal(le1), .winner(win1), .game_over(go1)
  );

  turn_sched #(.WIDTH(8), .MAX_TRIES(2), .TRY_W(4)) dut2 (
    .clk(clk), .reset(rst2), .enter_a(enter_a2), .enter_b(enter_b2), .new_game(new_game2),
    .guess_a(guess_a2), .guess_b(guess_b2), .cmp_guess(cg2),
    .cmp_over(over2), .cmp_under(under2), .cmp_equal(equal2),
    .run_target(run2), .turn(turn2), .tries_a(ta2), .tries_b(tb2),
    .led_over(lo2), .led_under(lu2), .led_equal(le2), .winner(win2), .game_over(go2)
  );

  // Datapath models: free-running target while run_target, combinational compare
  always_ff @(posedge clk or posedge rst1)
    if (rst1) tgt1 <= '0;
    else if (run1) tgt1 <= tgt1 + 1'b1;
  always_ff @(posedge clk or posedge rst2)
    if (rst2) tgt2 <= '0;
    else if (run2) tgt2 <= tgt2 + 1'b1;

  assign over1  = cg1 > tgt1;
  assign under1 = cg1 < tgt1;
  assign equal1 = cg1 == tgt1;
  assign over2  = cg2 > tgt2;
  assign under2 = cg2 < tgt2;
  assign equal2 = cg2 == tgt2;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full press/release turn on instance 1; guess is target+off at release
  task automatic play1(input bit pb, input int off);
    if (pb) enter_b1 = 1'b1; else enter_a1 = 1'b1;
    step(1);
    if (pb) guess_b1 = tgt1 + 8'(off); else guess_a1 = tgt1 + 8'(off);
    enter_a1 = 1'b0;
    enter_b1 = 1'b0;
    step(2);
  endtask

  task automatic play2(input bit pb, input int off);
    if (pb) enter_b2 = 1'b1; else enter_a2 = 1'b1;
    step(1);
    if (pb) guess_b2 = tgt2 + 8'(off); else guess_a2 = tgt2 + 8'(off);
    enter_a2 = 1'b0;
    enter_b2 = 1'b0;
    step(2);
  endtask

  initial begin
    rst1 = 1'b1; enter_a1 = 1'b0; enter_b1 = 1'b0; new_game1 = 1'b0;
    guess_a1 = '0; guess_b1 = '0;
    rst2 = 1'b1; enter_a2 = 1'b0; enter_b2 = 1'b0; new_game2 = 1'b0;
    guess_a2 = '0; guess_b2 = '0;
    saved = '0;
    step(2);

    // Reset values
    chk("rst_turn", turn1, 0);
    chk("rst_tries_a", ta1, 7);
    chk("rst_tries_b", tb1, 7);
    chk("rst_cmp_guess", cg1, 0);
    chk("rst_leds", {lo1, lu1, le1}, 0);
    chk("rst_winner", win1, 0);
    chk("rst_game_over", go1, 0);
    chk("rst_run_target", run1, 1);
    rst1 = 1'b0;
    rst2 = 1'b0;

    // Target generation runs until A presses
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("gen_run_target", run1, 1);
    end
    enter_a1 = 1'b1;
    step(1);
    chk("rel_run_target", run1, 0);
    guess_a1 = tgt1;
    enter_a1 = 1'b0;
    step(1);
    chk("check_cmp_guess", cg1, {24'd0, tgt1});
    chk("check_winner_latency", win1, 0);
    step(1);
    chk("win_led_equal", le1, 1);
    chk("win_led_other", {lo1, lu1}, 0);
    chk("win_winner", win1, 2'b01);
    chk("win_game_over", go1, 1);
    chk("win_tries_a", ta1, 6);
    chk("win_tries_b", tb1, 7);

    // Presses in S_END are ignored
    enter_a1 = 1'b1;
    step(1);
    enter_a1 = 1'b0;
    step(2);
    chk("end_hold_tries_a", ta1, 6);
    chk("end_hold_winner", win1, 2'b01);
    chk("end_hold_game_over", go1, 1);

    // New game
    new_game1 = 1'b1;
    step(1);
    new_game1 = 1'b0;
    chk("ng_game_over", go1, 0);
    chk("ng_tries_a", ta1, 7);
    chk("ng_winner", win1, 0);
    chk("ng_leds", {lo1, lu1, le1}, 0);
    chk("ng_run_target", run1, 1);
    chk("ng_turn", turn1, 0);
    step(2);

    // A guesses low
    play1(1'b0, -3);
    saved = guess_a1;
    chk("under_led_under", lu1, 1);
    chk("under_led_equal", le1, 0);
    chk("under_tries_a", ta1, 6);
    chk("under_turn", turn1, 1);
    chk("under_game_over", go1, 0);

    // A out of turn is ignored
    play1(1'b0, 0);
    chk("oot_cmp_guess", cg1, {24'd0, saved});
    chk("oot_tries_a", ta1, 6);
    chk("oot_turn", turn1, 1);
    chk("oot_winner", win1, 0);

    // Simultaneous press on B's turn: only B latched
    guess_a1 = tgt1;
    enter_a1 = 1'b1;
    enter_b1 = 1'b1;
    step(1);
    guess_b1 = tgt1 + 8'd5;
    enter_a1 = 1'b0;
    enter_b1 = 1'b0;
    step(1);
    chk("sim_cmp_guess", cg1, {24'd0, tgt1 + 8'd5});
    step(1);
    chk("sim_led_over", lo1, 1);
    chk("sim_tries_b", tb1, 6);
    chk("sim_tries_a", ta1, 6);
    chk("sim_turn", turn1, 0);

    // A misses again so B has the turn, then reset while B holds enter in S_REL
    play1(1'b0, -1);
    chk("pre_rst_turn", turn1, 1);
    chk("pre_rst_tries_a", ta1, 5);
    enter_b1 = 1'b1;
    step(1);
    guess_b1 = tgt1;
    #1 rst1 = 1'b1;
    #1;
    chk("mid_rst_tries", {ta1, tb1}, 8'h77);
    chk("mid_rst_turn", turn1, 0);
    chk("mid_rst_cmp_guess", cg1, 0);
    chk("mid_rst_leds", {lo1, lu1, le1}, 0);
    chk("mid_rst_run_target", run1, 1);
    step(1);
    rst1 = 1'b0;
    step(2);
    enter_b1 = 1'b0;
    step(3);
    chk("post_rst_run_target", run1, 1);
    chk("post_rst_cmp_guess", cg1, 0);
    chk("post_rst_tries_b", tb1, 7);
    chk("post_rst_leds", {lo1, lu1, le1}, 0);

    // MAX_TRIES=2: alternating misses end in a draw
    play2(1'b0, -1);
    chk("d_a1_tries_a", ta2, 1);
    chk("d_a1_turn", turn2, 1);
    play2(1'b1, 1);
    chk("d_b1_tries_b", tb2, 1);
    chk("d_b1_led_over", lo2, 1);
    chk("d_b1_turn", turn2, 0);
    play2(1'b0, -2);
    chk("d_a2_tries_a", ta2, 0);
    chk("d_a2_turn", turn2, 1);
    chk("d_a2_game_over", go2, 0);
    play2(1'b1, 2);
    chk("d_b2_tries", {ta2, tb2}, 0);
    chk("d_b2_winner", win2, 2'b11);
    chk("d_b2_game_over", go2, 1);
    chk("d_b2_turn", turn2, 1);

    new_game2 = 1'b1;
    step(1);
    new_game2 = 1'b0;
    chk("d_ng_tries", {ta2, tb2}, 8'h22);
    chk("d_ng_winner", win2, 0);
    chk("d_ng_run_target", run2, 1);
    chk("d_ng_turn", turn2, 0);
    step(2);

    // B wins
    play2(1'b0, -1);
    play2(1'b1, 0);
    chk("bwin_winner", win2, 2'b10);
    chk("bwin_led_equal", le2, 1);
    chk("bwin_tries", {ta2, tb2}, 8'h11);
    chk("bwin_game_over", go2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
